// File: rtl/rr_arbiter4.sv
// Round-robin arbiter: rotating-priority search, registered one-hot grant, hold limit.
// Latency: 1 clock from sampled req to grant; release hands off with no idle bubble.
// Backpressure: none; the owner keeps the grant while req is high, up to MAX_HOLD cycles.
//
// Ports:
//   clk         - rising-edge clock
//   rst_n       - asynchronous active-low reset
//   req[N]      - level requests, one per requester
//   grant[N]    - registered one-hot grant, zero when idle
//   grant_valid - high when any grant bit is set
//   grant_id    - binary index of the granted requester, zero when idle
//   preempt     - one-cycle pulse when the grant was forcibly rotated by the hold limit
module rr_arbiter4 #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id,
    output logic            preempt
);

    localparam int CNT_W = $clog2(MAX_HOLD);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [ID_W-1:0]   last_owner;
    logic [CNT_W-1:0]  hold_cnt;

    logic [ID_W-1:0]   search_base;
    logic [N-1:0]      search_mask;
    logic [ID_W-1:0]   idx;
    logic [ID_W-1:0]   win_id;
    logic              found;
    logic              owner_req;

    // While busy the search starts just after the current owner and skips it, so a
    // rotation (release or preemption) can never hand the grant back to the owner.
    // While idle the grant is zero, so the mask is just req and the search starts
    // after the last owner.
    assign search_base = (state == BUSY) ? grant_id : last_owner;
    assign search_mask = req & ~grant;
    assign owner_req   = req[grant_id];

    // Rotating priority encoder: offsets 1..N from the base. N is a power of two,
    // so the ID_W-bit sum wraps modulo N for free; offset N lands back on the base.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = search_base + ID_W'(k);
            if (!found && search_mask[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            preempt     <= 1'b0;
            hold_cnt    <= '0;
            last_owner  <= ID_W'(N - 1);
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state       <= BUSY;
                        grant       <= N'(1) << win_id;
                        grant_valid <= 1'b1;
                        grant_id    <= win_id;
                        hold_cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (!owner_req) begin
                        // Release wins over the hold limit: never a preempt here.
                        last_owner <= grant_id;
                        hold_cnt   <= '0;
                        if (found) begin
                            grant    <= N'(1) << win_id;
                            grant_id <= win_id;
                        end else begin
                            state       <= IDLE;
                            grant       <= '0;
                            grant_valid <= 1'b0;
                            grant_id    <= '0;
                        end
                    end else if (hold_cnt != CNT_W'(MAX_HOLD - 1)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        // Hold limit reached; a lone owner simply restarts its window.
                        hold_cnt <= '0;
                        if (found) begin
                            last_owner <= grant_id;
                            grant      <= N'(1) << win_id;
                            grant_id   <= win_id;
                            preempt    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    grant_id    <= '0;
                    hold_cnt    <= '0;
                end
            endcase
        end
    end

endmodule
